// File: rtl/pool_max_stream.sv
// Streaming KxK max-pool, stride K, raster-order input.
// One row of partial column maxima (OUT_W words) is kept between pooled rows.
module pool_max_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 224,
    parameter int HEIGHT     = 224,
    parameter int POOL       = 2,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  valid_in,
    input  logic                  sof,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  valid_out,
    output logic                  o_last,
    output logic                  frame_done
);
    localparam int OUT_W = WIDTH / POOL;
    localparam int OUT_H = HEIGHT / POOL;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int RW    = $clog2(HEIGHT + 1);
    localparam int KW    = $clog2(POOL + 1);
    localparam int OW    = $clog2(OUT_W + 1);
    localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_SKIP = RW'(OUT_H * POOL);
    localparam logic [RW-1:0] ROW_END  = RW'(OUT_H * POOL - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(POOL - 1);
    localparam logic [OW-1:0] OC_LAST  = OW'(OUT_W - 1);
    localparam logic [OW-1:0] OC_LIM   = OW'(OUT_W);

    typedef enum logic [1:0] {FILL, EMIT, SKIP} state_t;

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [KW-1:0]         r_kc;
    logic [KW-1:0]         r_ph;
    logic [OW-1:0]         r_oc;
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_hmax;
    logic [DATA_WIDTH-1:0] r_buf_rd;
    logic [DATA_WIDTH-1:0] r_buf [OUT_W];

    logic [CW-1:0]         w_col;
    logic [RW-1:0]         w_row;
    logic [KW-1:0]         w_kc;
    logic [KW-1:0]         w_ph;
    logic [KW-1:0]         w_ph_next;
    logic [OW-1:0]         w_oc;
    logic [AW-1:0]         w_addr;
    state_t                w_state;
    logic [DATA_WIDTH-1:0] w_hmax;
    logic [DATA_WIDTH-1:0] w_vmax;
    logic                  w_seg_end;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_acc;

    function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    // sof forces the accepted pixel to (row 0, col 0) regardless of the counters
    always_comb begin
        w_col      = sof ? '0 : r_col;
        w_row      = sof ? '0 : r_row;
        w_kc       = sof ? '0 : r_kc;
        w_ph       = sof ? '0 : r_ph;
        w_oc       = sof ? '0 : r_oc;
        w_state    = sof ? FILL : r_state;
        w_addr     = w_oc[AW-1:0];
        w_ph_next  = (w_ph == K_LAST) ? '0 : w_ph + 1'b1;
        w_hmax     = (w_kc == '0 || gt(i_data, r_hmax)) ? i_data : r_hmax;
        w_vmax     = gt(w_hmax, r_buf_rd) ? w_hmax : r_buf_rd;
        w_seg_end  = (w_kc == K_LAST) && (w_oc < OC_LIM);
        w_col_last = (w_col == COL_LAST);
        w_row_last = (w_row == ROW_LAST);
        w_acc      = valid_in && !rst;
    end

    // Column entry is fetched at a segment's first pixel; POOL >= 2 keeps it apart from the write.
    always_ff @(posedge clk) begin
        if (w_acc && w_kc == '0 && w_oc < OC_LIM)
            r_buf_rd <= r_buf[w_addr];
        if (w_acc && w_seg_end)
            r_buf[w_addr] <= (w_ph == '0) ? w_hmax : w_vmax;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_kc       <= '0;
            r_ph       <= '0;
            r_oc       <= '0;
            r_state    <= FILL;
            r_hmax     <= '0;
            o_data     <= '0;
            valid_out  <= 1'b0;
            o_last     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            o_last     <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                r_hmax  <= w_hmax;
                r_row   <= w_row;
                r_ph    <= w_ph;
                r_state <= w_state;
                if (w_col_last) begin
                    r_col      <= '0;
                    r_kc       <= '0;
                    r_oc       <= '0;
                    frame_done <= w_row_last;
                    if (w_row_last) begin
                        r_row   <= '0;
                        r_ph    <= '0;
                        r_state <= FILL;
                    end else begin
                        r_row <= w_row + 1'b1;
                        r_ph  <= w_ph_next;
                        if (w_row + 1'b1 == ROW_SKIP || w_state == SKIP)
                            r_state <= SKIP;
                        else
                            r_state <= (w_ph_next == K_LAST) ? EMIT : FILL;
                    end
                end else begin
                    r_col <= w_col + 1'b1;
                    if (w_kc == K_LAST) begin
                        r_kc <= '0;
                        r_oc <= (w_oc < OC_LIM) ? w_oc + 1'b1 : w_oc;
                    end else begin
                        r_kc <= w_kc + 1'b1;
                        r_oc <= w_oc;
                    end
                end
                if (w_seg_end && w_state == EMIT) begin
                    o_data    <= w_vmax;
                    valid_out <= 1'b1;
                    o_last    <= (w_row == ROW_END) && (w_oc == OC_LAST);
                end
            end
        end
    end
endmodule

// File: tb/tb_pool_max_stream.sv
// Bench for pool_max_stream: four configurations driven one at a time, checked
// against a frame-array window-max model with cycle-exact output timing.
module tb_pool_max_stream;
    localparam int P_T [4] = '{2, 3, 2, 2};
    localparam int W_T [4] = '{4, 7, 2, 2};
    localparam int H_T [4] = '{4, 7, 2, 2};
    localparam int S_T [4] = '{1, 1, 1, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din  [4];
    logic        vin  [4];
    logic        sofi [4];
    logic [31:0] od   [4];
    logic        vo   [4];
    logic        ol   [4];
    logic        fd   [4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct { int d; logic [31:0] v; logic last; int cyc; } exp_t;
    typedef struct { int d; int cyc; } fd_t;
    exp_t eq [$];
    fd_t  fq [$];
    int          mrow [4];
    int          mcol [4];
    logic [31:0] last_val [4];
    logic [31:0] px [4][8][8];

    pool_max_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4), .POOL(2), .SIGNED(1)) u_p2 (
        .clk(clk), .rst(rst), .i_data(din[0]), .valid_in(vin[0]), .sof(sofi[0]),
        .o_data(od[0]), .valid_out(vo[0]), .o_last(ol[0]), .frame_done(fd[0]));
    pool_max_stream #(.DATA_WIDTH(32), .WIDTH(7), .HEIGHT(7), .POOL(3), .SIGNED(1)) u_p3 (
        .clk(clk), .rst(rst), .i_data(din[1]), .valid_in(vin[1]), .sof(sofi[1]),
        .o_data(od[1]), .valid_out(vo[1]), .o_last(ol[1]), .frame_done(fd[1]));
    pool_max_stream #(.DATA_WIDTH(32), .WIDTH(2), .HEIGHT(2), .POOL(2), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .i_data(din[2]), .valid_in(vin[2]), .sof(sofi[2]),
        .o_data(od[2]), .valid_out(vo[2]), .o_last(ol[2]), .frame_done(fd[2]));
    pool_max_stream #(.DATA_WIDTH(32), .WIDTH(2), .HEIGHT(2), .POOL(2), .SIGNED(0)) u_uns (
        .clk(clk), .rst(rst), .i_data(din[3]), .valid_in(vin[3]), .sof(sofi[3]),
        .o_data(od[3]), .valid_out(vo[3]), .o_last(ol[3]), .frame_done(fd[3]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit gt(input int d, input logic [31:0] a, input logic [31:0] b);
        if (S_T[d] != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    // Reference: store the frame, take the max over each completed window.
    task automatic model(input int d, input logic [31:0] v, input bit s, input int acc);
        int p, w, h, r, c;
        logic [31:0] m;
        p = P_T[d]; w = W_T[d]; h = H_T[d];
        if (s) begin mrow[d] = 0; mcol[d] = 0; end
        r = mrow[d]; c = mcol[d];
        px[d][r][c] = v;
        if (c % p == p - 1 && r % p == p - 1 && c / p < w / p && r / p < h / p) begin
            m = px[d][r-p+1][c-p+1];
            for (int rr = r - p + 1; rr <= r; rr++)
                for (int cc = c - p + 1; cc <= c; cc++)
                    if (gt(d, px[d][rr][cc], m)) m = px[d][rr][cc];
            eq.push_back('{d, m, (r / p == h / p - 1) && (c / p == w / p - 1), acc});
        end
        if (r == h - 1 && c == w - 1) fq.push_back('{d, acc});
        if (c == w - 1) begin
            mcol[d] = 0;
            mrow[d] = (r == h - 1) ? 0 : r + 1;
        end else begin
            mcol[d] = c + 1;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            mrow[d] = 0; mcol[d] = 0; last_val[d] = '0;
        end
        eq.delete();
        fq.delete();
    endtask

    task automatic clear_in();
        for (int d = 0; d < 4; d++) begin vin[d] = 1'b0; sofi[d] = 1'b0; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; clear_in(); end
    endtask

    task automatic drive(input int d, input logic [31:0] v, input bit s, input int gap);
        idle(gap);
        @(posedge clk); #1;
        clear_in();
        din[d] = v; vin[d] = 1'b1; sofi[d] = s;
        model(d, v, s, cyc + 1);
    endtask

    task automatic ramp(input int d, input int n, input int maxgap, input bit sof_first);
        for (int i = 0; i < n; i++)
            drive(d, i, sof_first && i == 0, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    endtask

    task automatic frame_rand(input int d, input int maxgap);
        for (int i = 0; i < W_T[d] * H_T[d]; i++)
            drive(d, $urandom, (i == 0) || ($urandom_range(0, 39) == 0),
                  $urandom_range(0, maxgap));
    endtask

    task automatic do_reset(input bit with_pixel);
        @(posedge clk); #1;
        clear_in();
        rst = 1'b1;
        if (with_pixel) begin din[0] = 32'd99; vin[0] = 1'b1; sofi[0] = 1'b1; end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_in();
        model_reset();
        for (int d = 0; d < 4; d++) begin
            check("rst_o_data", od[d], 32'd0);
            check("rst_valid_out", 32'(vo[d]), 32'd0);
            check("rst_o_last", 32'(ol[d]), 32'd0);
            check("rst_frame_done", 32'(fd[d]), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 4; d++) begin
                bit hit, fhit;
                hit  = (eq.size() > 0) && (eq[0].d == d) && (eq[0].cyc == cyc);
                fhit = (fq.size() > 0) && (fq[0].d == d) && (fq[0].cyc == cyc);
                if (hit) begin
                    check("valid_out", 32'(vo[d]), 32'd1);
                    check("o_data", od[d], eq[0].v);
                    check("o_last", 32'(ol[d]), 32'(eq[0].last));
                    last_val[d] = eq[0].v;
                    void'(eq.pop_front());
                end else begin
                    check("valid_idle", 32'(vo[d]), 32'd0);
                    check("o_last_idle", 32'(ol[d]), 32'd0);
                    check("o_data_hold", od[d], last_val[d]);
                end
                check("frame_done", 32'(fd[d]), 32'(fhit));
                if (fhit) void'(fq.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin din[d] = '0; vin[d] = 1'b0; sofi[d] = 1'b0; end
        repeat (3) @(posedge clk);
        do_reset(1'b0);
        mon_en = 1'b1;

        ramp(0, 16, 0, 1'b0);               // 4x4 ramp: 5,7,13,15
        idle(3);
        ramp(1, 49, 0, 1'b1);               // 7x7 K=3 ramp: 16,19,37,40
        idle(3);
        for (int d = 2; d < 4; d++) begin   // signed vs unsigned window
            drive(d, 32'hFFFF_FFFB, 1'b1, 0);
            drive(d, 32'd3, 1'b0, 0);
            drive(d, 32'hFFFF_FFF8, 1'b0, 0);
            drive(d, 32'd1, 1'b0, 0);
        end
        idle(3);
        ramp(0, 16, 3, 1'b0);               // gapped input
        idle(3);
        ramp(0, 6, 0, 1'b1);                // aborted frame, then resync
        ramp(0, 16, 0, 1'b1);
        idle(3);
        ramp(0, 10, 0, 1'b0);               // reset mid-frame, pixel during rst ignored
        idle(2);
        do_reset(1'b1);
        ramp(0, 16, 0, 1'b0);
        idle(3);
        for (int k = 0; k < 3; k++)
            for (int d = 0; d < 4; d++) begin
                frame_rand(d, 2);
                idle(2);
            end
        idle(5);

        check("pending_out", 32'(eq.size()), 32'd0);
        check("pending_frame_done", 32'(fq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
